// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Control/result bundle between a CPU-side agent and the PWM capture block.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic             en;
    logic             pwm_in;
    logic             cpu_ack;
    logic [WIDTH-1:0] high_time;
    logic [WIDTH-1:0] period;
    logic             meas_valid;
    logic             overrun;
    logic             timeout;
    logic             stuck_level;

    modport master (
        output en, pwm_in, cpu_ack,
        input  high_time, period, meas_valid, overrun, timeout, stuck_level
    );

    modport slave (
        input  en, pwm_in, cpu_ack,
        output high_time, period, meas_valid, overrun, timeout, stuck_level
    );

endinterface

// File: rtl/pwm_sync.sv
// Synchronizer chain for the asynchronous PWM line plus rise/fall pulse detection.
module pwm_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;
    // Edges are masked until both the last stage and its delayed copy hold real samples,
    // so a line already high at reset release is not mistaken for a rise.
    logic [Stages:0]   fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], async_i};
            prev_q <= sync_q[Stages-1];
            fill_q <= {fill_q[Stages-1:0], 1'b1};
        end
    end

    assign level_o = sync_q[Stages-1];
    assign rise_o  = fill_q[Stages] & level_o & ~prev_q;
    assign fall_o  = fill_q[Stages] & ~level_o & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM line in clock cycles, with sticky
// valid/overrun/timeout flags that a single-cycle CPU acknowledge clears.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst_n,
    pwm_capture_if.slave bus
);

    localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // One below saturation: stepping from here would make the counter all-ones.
    localparam logic [WIDTH-1:0] CntLimit = {{(WIDTH-1){1'b1}}, 1'b0};

    logic level, rise, fall;

    pwm_sync #(
        .Stages(Stages)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(bus.pwm_in),
        .level_o(level),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             stuck_q, stuck_d;
    logic             publish, saturate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hi_cnt_q    <= '0;
            per_cnt_q   <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_cnt_q    <= hi_cnt_d;
            per_cnt_q   <= per_cnt_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            stuck_q     <= stuck_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_cnt_d    = hi_cnt_q;
        per_cnt_d   = per_cnt_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        stuck_d     = stuck_q;
        publish     = 1'b0;
        saturate    = 1'b0;

        if (!bus.en) begin
            state_d   = StIdle;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d   = StHigh;
                        hi_cnt_d  = 1;
                        per_cnt_d = 1;
                    end else begin
                        hi_cnt_d  = '0;
                        per_cnt_d = '0;
                    end
                end
                StHigh: begin
                    if (per_cnt_q == CntLimit) begin
                        saturate = 1'b1;
                    end else if (fall) begin
                        state_d   = StLow;
                        per_cnt_d = per_cnt_q + 1'b1;
                    end else begin
                        hi_cnt_d  = hi_cnt_q + 1'b1;
                        per_cnt_d = per_cnt_q + 1'b1;
                    end
                end
                StLow: begin
                    if (rise) begin
                        publish   = 1'b1;
                        state_d   = StHigh;
                        hi_cnt_d  = 1;
                        per_cnt_d = 1;
                    end else if (per_cnt_q == CntLimit) begin
                        saturate = 1'b1;
                    end else begin
                        per_cnt_d = per_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (saturate) begin
            state_d   = StIdle;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end

        // A new result beats a coincident acknowledge; an acknowledged publish is no overrun.
        if (publish) begin
            high_time_d = hi_cnt_q;
            period_d    = per_cnt_q;
            valid_d     = 1'b1;
            overrun_d   = ~bus.cpu_ack & (overrun_q | valid_q);
        end else if (bus.cpu_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (saturate) begin
            timeout_d = 1'b1;
            stuck_d   = level;
        end else if (bus.cpu_ack) begin
            timeout_d = 1'b0;
        end
    end

    assign bus.high_time   = high_time_q;
    assign bus.period      = period_q;
    assign bus.meas_valid  = valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout     = timeout_q;
    assign bus.stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven patterns, directed corner sequences and a
// randomized run, all compared against a timestamp-based reference model.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int W   = DefaultWidth;
    localparam int S   = 2;
    localparam int Max = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.WIDTH(W)) bus ();

    pwm_capture #(
        .WIDTH      (W),
        .SYNC_STAGES(S)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: synchronized level is pwm_in delayed S edges; a measurement spans from
    // one detected rise (edge r) through a fall (edge f) to the next rise (edge t).
    bit m_q[$];
    int m_n, m_r, m_f;
    bit m_armed;
    int m_hi, m_per;
    bit m_mv, m_ovr, m_tmo, m_stuck;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_n = 0; m_r = 0; m_f = -1; m_armed = 0;
        m_hi = 0; m_per = 0; m_mv = 0; m_ovr = 0; m_tmo = 0; m_stuck = 0;
    endtask

    task automatic model_step(input bit p, input bit e, input bit a);
        bit have, cur, prv, rise, fall, pub, tmo;
        int sz;
        m_n++;
        sz   = m_q.size();
        have = (sz == S + 1);
        cur  = (sz >= S) ? m_q[sz-S] : 1'b0;
        prv  = have ? m_q[sz-S-1] : 1'b0;
        rise = have && cur && !prv;
        fall = have && !cur && prv;
        pub  = 0;
        tmo  = 0;
        if (!e) begin
            m_armed = 0;
        end else if (!m_armed) begin
            if (rise) begin m_armed = 1; m_r = m_n; m_f = -1; end
        end else if (rise && m_f >= 0) begin
            pub   = 1;
            m_hi  = m_f - m_r;
            m_per = m_n - m_r;
            m_r   = m_n;
            m_f   = -1;
        end else if (m_n - m_r == Max - 1) begin
            tmo     = 1;
            m_armed = 0;
        end else if (fall) begin
            m_f = m_n;
        end
        if (pub) begin
            m_ovr = a ? 1'b0 : (m_ovr | m_mv);
            m_mv  = 1;
        end else if (a) begin
            m_mv  = 0;
            m_ovr = 0;
        end
        if (tmo) begin m_tmo = 1; m_stuck = cur; end
        else if (a) m_tmo = 0;
        m_q.push_back(p);
        if (m_q.size() > S + 1) void'(m_q.pop_front());
    endtask

    task automatic check_model();
        check("high_time", bus.high_time, m_hi);
        check("period", bus.period, m_per);
        check("meas_valid", bus.meas_valid, m_mv);
        check("overrun", bus.overrun, m_ovr);
        check("timeout", bus.timeout, m_tmo);
        check("stuck_level", bus.stuck_level, m_stuck);
    endtask

    task automatic cycle(input bit p, input bit e, input bit a);
        bus.pwm_in  = p;
        bus.en      = e;
        bus.cpu_ack = a;
        model_step(p, e, a);
        @(negedge clk);
        check_model();
    endtask

    task automatic pulse_train(input int hi, input int lo, input int periods);
        for (int k = 0; k < periods; k++) begin
            repeat (hi) cycle(1, 1, 0);
            repeat (lo) cycle(0, 1, 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        check("rst high_time", bus.high_time, 0);
        check("rst period", bus.period, 0);
        check("rst meas_valid", bus.meas_valid, 0);
        check("rst timeout", bus.timeout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rcycle(input bit p);
        bit e, a;
        e = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
        a = ($urandom_range(0, 7) == 0);
        cycle(p, e, a);
    endtask

    typedef struct {
        int hi;
        int lo;
        int exp_hi;
        int exp_per;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{hi: 1,   lo: 1,   exp_hi: 1,   exp_per: 2};
        vecs[1] = '{hi: 2,   lo: 1,   exp_hi: 2,   exp_per: 3};
        vecs[2] = '{hi: 1,   lo: 7,   exp_hi: 1,   exp_per: 8};
        vecs[3] = '{hi: 10,  lo: 20,  exp_hi: 10,  exp_per: 30};
        vecs[4] = '{hi: 100, lo: 154, exp_hi: 100, exp_per: 254};
        vecs[5] = '{hi: 3,   lo: 5,   exp_hi: 3,   exp_per: 8};

        bus.pwm_in  = 1'b0;
        bus.en      = 1'b0;
        bus.cpu_ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_model();
        check("reset meas_valid", bus.meas_valid, 0);
        check("reset period", bus.period, 0);
        rst_n = 1'b1;

        // Table: three periods plus the closing rise, never acknowledged.
        foreach (vecs[i]) begin
            repeat (3) cycle(0, 0, 0);
            cycle(0, 0, 1);
            repeat (S + 2) cycle(0, 1, 0);
            pulse_train(vecs[i].hi, vecs[i].lo, 3);
            repeat (S + 1) cycle(1, 1, 0);
            check("vec high_time", bus.high_time, vecs[i].exp_hi);
            check("vec period", bus.period, vecs[i].exp_per);
            check("vec meas_valid", bus.meas_valid, 1);
            check("vec overrun", bus.overrun, 1);
            check("vec timeout", bus.timeout, 0);
        end

        // Acknowledge on the exact publish edge, then a no-op acknowledge.
        repeat (3) cycle(0, 0, 0);
        cycle(0, 0, 1);
        repeat (S + 2) cycle(0, 1, 0);
        pulse_train(3, 5, 2);
        check("pre-ack meas_valid", bus.meas_valid, 1);
        for (int i = 0; i <= S; i++) cycle(1, 1, (i == S));
        check("ackpub meas_valid", bus.meas_valid, 1);
        check("ackpub overrun", bus.overrun, 0);
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        check("noop high_time", bus.high_time, 3);
        check("noop period", bus.period, 8);
        check("noop meas_valid", bus.meas_valid, 0);

        // Line stuck high: saturation sets timeout despite a coincident acknowledge.
        repeat (4) cycle(0, 0, 0);
        repeat (2) cycle(0, 1, 0);
        for (int i = 0; i < 300; i++) cycle(1, 1, (i == S + Max - 1));
        check("stuck timeout", bus.timeout, 1);
        check("stuck level", bus.stuck_level, 1);
        check("stuck high_time", bus.high_time, 3);
        check("stuck period", bus.period, 8);
        check("stuck meas_valid", bus.meas_valid, 0);

        // Enable dropped mid-HIGH and restored while the line is still high.
        repeat (4) cycle(0, 1, 0);
        cycle(0, 1, 1);
        repeat (6) cycle(1, 1, 0);
        repeat (3) cycle(1, 0, 0);
        repeat (5) cycle(1, 1, 0);
        repeat (5) cycle(0, 1, 0);
        check("en-drop no result", bus.meas_valid, 0);
        pulse_train(4, 6, 1);
        check("en-drop first period", bus.meas_valid, 0);
        repeat (S + 1) cycle(1, 1, 0);
        check("en-drop meas_valid", bus.meas_valid, 1);
        check("en-drop high_time", bus.high_time, 4);
        check("en-drop period", bus.period, 10);

        // Reset during LOW, released with the line already high.
        repeat (3) cycle(0, 1, 0);
        bus.pwm_in = 1'b1;
        do_reset();
        repeat (5) cycle(1, 1, 0);
        repeat (5) cycle(0, 1, 0);
        pulse_train(3, 5, 1);
        repeat (S) cycle(1, 1, 0);
        check("post-rst early", bus.meas_valid, 0);
        cycle(1, 1, 0);
        check("post-rst meas_valid", bus.meas_valid, 1);
        check("post-rst high_time", bus.high_time, 3);
        check("post-rst period", bus.period, 8);

        // Randomized run against the model.
        for (int k = 0; k < 80; k++) begin
            int hi, lo;
            hi = $urandom_range(1, 20);
            lo = $urandom_range(1, 20);
            if ($urandom_range(0, 15) == 0) hi = 300;
            else if ($urandom_range(0, 15) == 0) lo = 300;
            repeat (hi) rcycle(1);
            repeat (lo) rcycle(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
